// File: rtl/pipe_scroller_pkg.sv
// Shared screen geometry and pipe-scroller types.
// Ground and pipe blocks both import these so the scroll period and ground line agree.
package pipe_scroller_pkg;

  localparam int SCR_W           = 640;
  localparam int SCR_H           = 480;
  localparam int SCR_GROUND_Y    = 425;
  localparam int SCR_GROUND_TILE = 336;
  localparam int SCR_BIRD_X      = 200;

  localparam int PIPE_W_PX   = 52;
  localparam int PIPE_WRAP_W = SCR_W + PIPE_W_PX;
  localparam int LFSR_W      = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [8:0]        GAP_RESET = 9'd160;

  typedef struct packed {
    logic       act;
    logic [8:0] gap;
    logic [9:0] r;
  } pipe_t;

  function automatic logic [LFSR_W-1:0] nibble_swap(input logic [LFSR_W-1:0] v);
    return {v[3:0], v[7:4]};
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Frame/pixel inputs and pipe outputs of the scroller.
// The master drives frame strobe, game state, speed and pixel position; the slave returns pipe state.
interface pipe_scroller_if;

  logic       fresh;
  logic       game_status;
  logic [3:0] speed;
  logic [9:0] x;
  logic [8:0] y;
  logic       is_pipe;
  logic       score_tick;
  logic [9:0] pipe0_r;
  logic [9:0] pipe1_r;
  logic [8:0] gap0_top;
  logic [8:0] gap1_top;

  modport master (
    output fresh, game_status, speed, x, y,
    input  is_pipe, score_tick, pipe0_r, pipe1_r, gap0_top, gap1_top
  );

  modport slave (
    input  fresh, game_status, speed, x, y,
    output is_pipe, score_tick, pipe0_r, pipe1_r, gap0_top, gap1_top
  );

endinterface

// File: rtl/pipe_scroller_lfsr.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running every clock.
// The seed is loaded while reset is held.
module pipe_lfsr
  import pipe_scroller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_lfsr = r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= i_seed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Two scrolling pipes: per-frame scroll with wrap/respawn, scoring pulse and registered pixel hit.
// Pipe state only changes on the restart event or on a frame event while playing.
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
    parameter int WRAP_W   = PIPE_WRAP_W,
    parameter int PIPE_W   = PIPE_W_PX,
    parameter int GAP_H    = 100,
    parameter int GAP_MIN  = 60,
    parameter int GROUND_Y = SCR_GROUND_Y,
    parameter int BIRD_X   = SCR_BIRD_X
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_scroller_if.slave  bus
);

    localparam logic [10:0] WRAP11   = 11'(WRAP_W);
    localparam logic [10:0] PIPE11   = 11'(PIPE_W);
    localparam logic [9:0]  R0_START = 10'(WRAP_W - 1);
    localparam logic [9:0]  R1_START = 10'(WRAP_W / 2 - 1);
    localparam logic [9:0]  BIRD10   = 10'(BIRD_X);
    localparam logic [9:0]  GAPH10   = 10'(GAP_H);
    localparam logic [8:0]  GROUND9  = 9'(GROUND_Y);
    localparam logic [8:0]  GAPMIN9  = 9'(GAP_MIN);

    pipe_t       r_pipe [2];
    logic        r_fresh_d;
    logic        r_gs_d;
    logic        r_run;
    logic        r_is_pipe;
    logic        r_score_tick;

    logic [7:0]  w_lfsr;
    logic [7:0]  w_rand  [2];
    logic [10:0] w_diff  [2];
    logic        w_wrap  [2];
    logic [9:0]  w_r_new [2];
    logic        w_pass  [2];
    logic        w_hit   [2];
    logic        w_frame_ev;
    logic        w_start_ev;

    pipe_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_seed (LFSR_SEED),
        .o_lfsr (w_lfsr)
    );

    // r_run masks the first clock after reset so a low fresh at release is not taken as an edge.
    assign w_frame_ev = r_fresh_d & ~bus.fresh & r_run;
    assign w_start_ev = bus.game_status & ~r_gs_d;

    // A lone respawn takes the raw LFSR; pipe1 only swaps nibbles when pipe0 respawns too.
    assign w_rand[0] = w_lfsr;
    assign w_rand[1] = w_wrap[0] ? nibble_swap(w_lfsr) : w_lfsr;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_diff[i]  = {1'b0, r_pipe[i].r} - {7'd0, bus.speed};
            w_wrap[i]  = w_diff[i][10];
            w_r_new[i] = w_wrap[i] ? 10'(w_diff[i] + WRAP11) : w_diff[i][9:0];
            w_pass[i]  = r_pipe[i].act & ~w_wrap[i] &
                         (r_pipe[i].r >= BIRD10) & (w_r_new[i] < BIRD10);
            // 11-bit compare keeps the left edge clipped correctly when r < PIPE_W.
            w_hit[i]   = r_pipe[i].act &
                         ({1'b0, bus.x} < {1'b0, r_pipe[i].r}) &
                         (({1'b0, bus.x} + PIPE11) >= {1'b0, r_pipe[i].r}) &
                         ((bus.y < r_pipe[i].gap) |
                          ({1'b0, bus.y} >= ({1'b0, r_pipe[i].gap} + GAPH10))) &
                         (bus.y < GROUND9);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe[0]    <= '{act: 1'b0, gap: GAP_RESET, r: R0_START};
            r_pipe[1]    <= '{act: 1'b0, gap: GAP_RESET, r: R1_START};
            r_fresh_d    <= 1'b1;
            r_gs_d       <= 1'b0;
            r_run        <= 1'b0;
            r_is_pipe    <= 1'b0;
            r_score_tick <= 1'b0;
        end else begin
            r_fresh_d    <= bus.fresh;
            r_gs_d       <= bus.game_status;
            r_run        <= 1'b1;
            r_is_pipe    <= w_hit[0] | w_hit[1];
            r_score_tick <= 1'b0;
            if (w_start_ev) begin
                r_pipe[0] <= '{act: 1'b1, gap: GAPMIN9 + {1'b0, w_lfsr}, r: R0_START};
                r_pipe[1] <= '{act: 1'b0, gap: GAPMIN9 + {1'b0, nibble_swap(w_lfsr)}, r: R1_START};
            end else if (w_frame_ev && bus.game_status) begin
                for (int i = 0; i < 2; i++) begin
                    r_pipe[i].r <= w_r_new[i];
                    if (w_wrap[i]) begin
                        r_pipe[i].act <= 1'b1;
                        r_pipe[i].gap <= GAPMIN9 + {1'b0, w_rand[i]};
                    end
                end
                r_score_tick <= w_pass[0] | w_pass[1];
            end
        end
    end

    assign bus.is_pipe    = r_is_pipe;
    assign bus.score_tick = r_score_tick;
    assign bus.pipe0_r    = r_pipe[0].r;
    assign bus.pipe1_r    = r_pipe[1].r;
    assign bus.gap0_top   = r_pipe[0].gap;
    assign bus.gap1_top   = r_pipe[1].gap;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: directed scenarios plus randomized frames,
// every cycle compared against a frame-level behavioural model.
module tb_pipe_scroller;
  import pipe_scroller_pkg::*;

  localparam int WRAP_W   = 692;
  localparam int PIPE_W   = 52;
  localparam int GAP_H    = 100;
  localparam int GAP_MIN  = 60;
  localparam int GROUND_Y = 425;
  localparam int BIRD_X   = 200;
  localparam int OUT_W    = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_scroller_if bus ();

  pipe_scroller #(
    .WRAP_W(WRAP_W), .PIPE_W(PIPE_W), .GAP_H(GAP_H),
    .GAP_MIN(GAP_MIN), .GROUND_Y(GROUND_Y), .BIRD_X(BIRD_X)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  int ticks_seen = 0;
  bit rand_xy = 1'b1;
  logic [OUT_W-1:0] exp_q[$];

  // reference model: pipe positions as plain integers
  int m_r[2];
  int m_gap[2];
  bit m_act[2];
  int m_lfsr;
  int m_ev_lfsr;
  bit m_fresh_d;
  bit m_gs_d;
  bit m_tick;
  bit m_pipe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) & 255) | fb;
  endfunction

  function automatic int swap4(input int v);
    return ((v & 15) << 4) | ((v >> 4) & 15);
  endfunction

  function automatic void m_reset();
    m_r[0] = WRAP_W - 1;
    m_r[1] = WRAP_W / 2 - 1;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    m_gap[0] = 160;
    m_gap[1] = 160;
    m_lfsr = 'hA5;
    m_fresh_d = 1'b1;
    m_gs_d = 1'b0;
    m_tick = 1'b0;
    m_pipe = 1'b0;
  endfunction

  function automatic bit m_hit(input int i, input int xx, input int yy);
    return m_act[i] && (xx < m_r[i]) && (xx + PIPE_W >= m_r[i]) &&
           ((yy < m_gap[i]) || (yy >= m_gap[i] + GAP_H)) && (yy < GROUND_Y);
  endfunction

  // one rising clock edge of the model, using the inputs currently driven
  function automatic void m_clock();
    int spd, nr, xx, yy;
    bit fe, se, playing, wrap0;
    spd = int'(bus.speed);
    xx = int'(bus.x);
    yy = int'(bus.y);
    playing = bus.game_status;
    m_pipe = m_hit(0, xx, yy) || m_hit(1, xx, yy);
    fe = m_fresh_d && !bus.fresh;
    se = playing && !m_gs_d;
    m_tick = 1'b0;
    if (se) begin
      m_ev_lfsr = m_lfsr;
      m_r[0] = WRAP_W - 1;
      m_r[1] = WRAP_W / 2 - 1;
      m_act[0] = 1'b1;
      m_act[1] = 1'b0;
      m_gap[0] = GAP_MIN + m_lfsr;
      m_gap[1] = GAP_MIN + swap4(m_lfsr);
    end else if (fe && playing) begin
      m_ev_lfsr = m_lfsr;
      wrap0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        nr = m_r[i] - spd;
        if (nr < 0) begin
          nr += WRAP_W;
          m_act[i] = 1'b1;
          m_gap[i] = GAP_MIN + ((i == 1 && wrap0) ? swap4(m_lfsr) : m_lfsr);
          if (i == 0) wrap0 = 1'b1;
        end else if (m_act[i] && m_r[i] >= BIRD_X && nr < BIRD_X) begin
          m_tick = 1'b1;
        end
        m_r[i] = nr;
      end
    end
    m_fresh_d = bus.fresh;
    m_gs_d = playing;
    m_lfsr = lfsr_next(m_lfsr);
  endfunction

  // one clock: model update at posedge, compare at negedge, new pixel drive
  task automatic step();
    logic [OUT_W-1:0] e;
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_clock();
    exp_q.push_back({m_pipe, m_tick, 10'(m_r[0]), 10'(m_r[1]), 9'(m_gap[0]), 9'(m_gap[1])});
    @(negedge clk);
    e = exp_q.pop_front();
    if (bus.score_tick === 1'b1) ticks_seen++;
    chk("is_pipe",    32'(bus.is_pipe),    32'(e[39]));
    chk("score_tick", 32'(bus.score_tick), 32'(e[38]));
    chk("pipe0_r",    32'(bus.pipe0_r),    32'(e[37:28]));
    chk("pipe1_r",    32'(bus.pipe1_r),    32'(e[27:18]));
    chk("gap0_top",   32'(bus.gap0_top),   32'(e[17:9]));
    chk("gap1_top",   32'(bus.gap1_top),   32'(e[8:0]));
    if (rand_xy) begin
      bus.x = 10'($urandom_range(0, 700));
      bus.y = 9'($urandom_range(0, 511));
    end
  endtask

  // driver: fresh high for hi clocks, then low for lo clocks (falling edge = frame event)
  task automatic frame(input int spd, input int hi, input int lo);
    bus.speed = 4'(spd);
    bus.fresh = 1'b1;
    repeat (hi) step();
    bus.fresh = 1'b0;
    repeat (lo) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p0"},   32'(bus.pipe0_r),    32'd691);
    chk({tag, "_p1"},   32'(bus.pipe1_r),    32'd345);
    chk({tag, "_g0"},   32'(bus.gap0_top),   32'd160);
    chk({tag, "_g1"},   32'(bus.gap1_top),   32'd160);
    chk({tag, "_pix"},  32'(bus.is_pipe),    32'd0);
    chk({tag, "_tick"}, 32'(bus.score_tick), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_g0, saved_g1;
    bus.fresh = 1'b1;
    bus.game_status = 1'b0;
    bus.speed = 4'd0;
    bus.x = 10'd0;
    bus.y = 9'd0;
    m_reset();

    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // restart then 10 frames at speed 3
    bus.game_status = 1'b1;
    step();
    chk("start_p0", 32'(bus.pipe0_r), 32'd691);
    chk("start_p1", 32'(bus.pipe1_r), 32'd345);
    ticks_seen = 0;
    repeat (10) frame(3, 2, 2);
    chk("scroll10_p0", 32'(bus.pipe0_r), 32'd661);
    chk("scroll10_p1", 32'(bus.pipe1_r), 32'd315);
    chk("scroll10_ticks", 32'(ticks_seen), 32'd0);

    // approach the bird column, then cross it 201 -> 198
    repeat (46) frame(10, 1, 1);
    chk("pre_bird_p0", 32'(bus.pipe0_r), 32'd201);
    chk("pre_bird_ticks", 32'(ticks_seen), 32'd0);
    frame(3, 1, 1);
    chk("bird_p0", 32'(bus.pipe0_r), 32'd198);
    chk("bird_ticks", 32'(ticks_seen), 32'd1);

    // wrap pipe0 from r=2 at speed 3
    repeat (14) frame(14, 1, 1);
    chk("pre_wrap_p0", 32'(bus.pipe0_r), 32'd2);
    chk("pre_wrap_p1", 32'(bus.pipe1_r), 32'd348);
    saved_g1 = m_gap[1];
    frame(3, 1, 1);
    chk("wrap_p0", 32'(bus.pipe0_r), 32'd691);
    chk("wrap_g0", 32'(bus.gap0_top), 32'(GAP_MIN + m_ev_lfsr));
    chk("wrap_p1", 32'(bus.pipe1_r), 32'd345);
    chk("wrap_g1", 32'(bus.gap1_top), 32'(saved_g1));

    // bring pipe0 to r=30 and scan the left-edge clip
    repeat (44) frame(15, 1, 1);
    frame(1, 1, 1);
    chk("clip_p0", 32'(bus.pipe0_r), 32'd30);
    chk("clip_p1", 32'(bus.pipe1_r), 32'd376);
    rand_xy = 1'b0;
    bus.fresh = 1'b1;
    for (int xx = 0; xx <= 40; xx++) begin
      bus.x = 10'(xx);
      bus.y = 9'd50;
      step();
      chk("scan_y50", 32'(bus.is_pipe), 32'(xx < 30));
    end
    for (int xx = 0; xx <= 40; xx += 5) begin
      bus.x = 10'(xx);
      bus.y = 9'(m_gap[0] + 50);
      step();
      chk("scan_gap", 32'(bus.is_pipe), 32'd0);
      bus.y = 9'd430;
      step();
      chk("scan_ground", 32'(bus.is_pipe), 32'd0);
    end
    rand_xy = 1'b1;

    // frozen while idle, then restart reloads
    saved_g0 = m_gap[0];
    saved_g1 = m_gap[1];
    ticks_seen = 0;
    bus.game_status = 1'b0;
    step();
    repeat (5) frame(7, 2, 2);
    chk("idle_p0", 32'(bus.pipe0_r), 32'd30);
    chk("idle_p1", 32'(bus.pipe1_r), 32'd376);
    chk("idle_g0", 32'(bus.gap0_top), 32'(saved_g0));
    chk("idle_g1", 32'(bus.gap1_top), 32'(saved_g1));
    chk("idle_ticks", 32'(ticks_seen), 32'd0);
    bus.fresh = 1'b1;
    bus.game_status = 1'b1;
    step();
    chk("restart_p0", 32'(bus.pipe0_r), 32'd691);
    chk("restart_p1", 32'(bus.pipe1_r), 32'd345);
    chk("restart_g0", 32'(bus.gap0_top), 32'(GAP_MIN + m_ev_lfsr));
    chk("restart_g1", 32'(bus.gap1_top), 32'(GAP_MIN + swap4(m_ev_lfsr)));

    // reset coincident with a frame event
    repeat (5) frame(9, 1, 1);
    bus.fresh = 1'b1;
    step();
    ticks_seen = 0;
    bus.fresh = 1'b0;
    rst_n = 1'b0;
    step();
    chk_reset_vals("rst_frame");
    step();
    chk_reset_vals("rst_hold");
    chk("rst_ticks", 32'(ticks_seen), 32'd0);
    bus.fresh = 1'b1;
    rst_n = 1'b1;
    step();
    chk("rel_p0", 32'(bus.pipe0_r), 32'd691);
    chk("rel_p1", 32'(bus.pipe1_r), 32'd345);
    chk("rel_g0", 32'(bus.gap0_top), 32'd225);
    chk("rel_g1", 32'(bus.gap1_top), 32'd150);

    // randomized frames
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) bus.game_status = ~bus.game_status;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step();
        bus.fresh = 1'b1;
        rst_n = 1'b1;
      end
      frame($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
